// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : decoder_pkg
//  Purpose   : Shared constants and helper function for index_decoder_dispatch
//  Revision  : 1.0  initial release
// ============================================================================
package decoder_pkg;

    localparam int IDX_W      = 3;
    localparam int N          = 2 ** IDX_W;
    localparam int CNT_W      = $clog2(N + 1);
    localparam int DROP_CNT_W = 8;

    // Decode a channel index into a one-hot channel vector
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_n.sv
`default_nettype none
// ============================================================================
//  Module    : popcount_n
//  Purpose   : Combinational population count of an N-bit vector
//  Revision  : 1.0  initial release
// ============================================================================
module popcount_n #(
    parameter int N = 8
) (
    input  logic [N-1:0]           vec,
    output logic [$clog2(N+1)-1:0] cnt
);

    localparam int CW = $clog2(N + 1);

    // Sum every bit; CW is wide enough to hold the all-ones count N
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/index_decoder_dispatch.sv
`default_nettype none
// ============================================================================
//  Module    : index_decoder_dispatch
//  Purpose   : Accepts index codes over valid/ready, decodes them to one-hot
//              and accumulates them in a pending register cleared per bit by
//              ack or wholesale by flush. Reports merged (dropped) events.
//  Options   : DISPATCH_DROP_CNT_EN - builds the saturating drop counter;
//              when undefined drop_cnt reads constant zero.
//  Revision  : 1.0  initial release
// ============================================================================
module index_decoder_dispatch
    import decoder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  flush,
    input  logic [N-1:0]          ack,
    output logic [N-1:0]          pending,
    output logic [CNT_W-1:0]      pend_cnt,
    output logic                  irq,
    output logic                  drop,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic             r_rdy;
    logic             w_accept;
    logic [N-1:0]     w_set;
    logic [N-1:0]     w_pend_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_drop;

    // Ready is cleared asynchronously by reset and comes back on the first edge after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdy <= 1'b0;
        else     r_rdy <= 1'b1;
    end

    assign in_ready = r_rdy & ~flush;
    assign w_accept = in_valid & in_ready;

    // Next-state: flush beats set, set beats ack, ack beats hold
    always_comb begin
        w_set      = w_accept ? onehot(in_idx) : '0;
        w_pend_nxt = flush ? '0 : (w_set | (pending & ~ack));
        // A hit on a still-pending bit merges into it unless the same cycle acks it
        w_drop     = w_accept & pending[in_idx] & ~ack[in_idx];
    end

    popcount_n #(
        .N   (N)
    ) u_popcount (
        .vec (w_pend_nxt),
        .cnt (w_cnt_nxt)
    );

    // Pending register with count and interrupt derived from the same next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            pend_cnt <= '0;
            irq      <= 1'b0;
            drop     <= 1'b0;
        end else begin
            pending  <= w_pend_nxt;
            pend_cnt <= w_cnt_nxt;
            irq      <= |w_pend_nxt;
            drop     <= w_drop;
        end
    end

`ifdef DISPATCH_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    // Saturating drop counter; only reset clears it, flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= '0;
        else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}}))
            r_drop_cnt <= r_drop_cnt + 1'b1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_index_decoder_dispatch.sv
`default_nettype none
// ============================================================================
//  Module    : tb_index_decoder_dispatch
//  Purpose   : Self-checking bench for index_decoder_dispatch
//  Revision  : 1.0  initial release
// ============================================================================
module tb_index_decoder_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic       flush;
    logic [7:0] ack;
    logic [7:0] pending;
    logic [3:0] pend_cnt;
    logic       irq;
    logic       drop;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pend;
        logic [3:0] cnt;
        logic       irq;
        logic       drop;
        logic [7:0] dcnt;
    } exp_t;

    exp_t sb[$];

    // Reference state kept by the bench
    logic [7:0] m_pend = '0;
    logic [7:0] m_dcnt = '0;
    logic       m_rdy  = 1'b0;

    index_decoder_dispatch dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .flush    (flush),
        .ack      (ack),
        .pending  (pending),
        .pend_cnt (pend_cnt),
        .irq      (irq),
        .drop     (drop),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus: called at a negedge, returns at the next negedge
    task automatic step(input logic v, input logic [2:0] idx, input logic fl, input logic [7:0] ak);
        logic       acc;
        logic       dr;
        logic [7:0] nxt;
        exp_t       e;
        exp_t       got;
        in_valid = v;
        in_idx   = idx;
        flush    = fl;
        ack      = ak;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy & ~fl});
        acc = v & m_rdy & ~fl;
        for (int i = 0; i < 8; i++) begin
            if (fl)                       nxt[i] = 1'b0;
            else if (acc && idx == 3'(i)) nxt[i] = 1'b1;
            else if (ak[i])               nxt[i] = 1'b0;
            else                          nxt[i] = m_pend[i];
        end
        dr = acc & m_pend[idx] & ~ak[idx];
`ifdef DISPATCH_DROP_CNT_EN
        if (dr && m_dcnt != 8'hFF) m_dcnt = m_dcnt + 8'd1;
`else
        m_dcnt = 8'h00;
`endif
        e.pend = nxt;
        e.cnt  = 4'($countones(nxt));
        e.irq  = |nxt;
        e.drop = dr;
        e.dcnt = m_dcnt;
        sb.push_back(e);
        @(posedge clk);
        m_pend = nxt;
        m_rdy  = 1'b1;
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("pending",  {24'd0, pending},  {24'd0, got.pend});
            chk("pend_cnt", {28'd0, pend_cnt}, {28'd0, got.cnt});
            chk("irq",      {31'd0, irq},      {31'd0, got.irq});
            chk("drop",     {31'd0, drop},     {31'd0, got.drop});
            chk("drop_cnt", {24'd0, drop_cnt}, {24'd0, got.dcnt});
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_idx = '0; flush = 1'b0; ack = '0;
        #1;
        // Reset state, including ready held low
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_pending",  {24'd0, pending},  32'd0);
        chk("rst_pend_cnt", {28'd0, pend_cnt}, 32'd0);
        chk("rst_irq",      {31'd0, irq},      32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3'd0, 1'b0, 8'h00);          // ready comes back on this edge

        // 1: single code 5
        step(1'b1, 3'd5, 1'b0, 8'h00);
        chk("t1_pending", {24'd0, pending}, 32'h20);
        step(1'b0, 3'd0, 1'b0, 8'h20);

        // 2: all codes back-to-back, then ack everything
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 1'b0, 8'h00);
        chk("t2_full_cnt", {28'd0, pend_cnt}, 32'd8);
        step(1'b0, 3'd0, 1'b0, 8'hFF);
        chk("t2_cleared", {24'd0, pending}, 32'h00);

        // 3: drop on pending bit, then same code with its ack (new event)
        step(1'b1, 3'd3, 1'b0, 8'h00);
        step(1'b1, 3'd3, 1'b0, 8'h00);
        step(1'b0, 3'd0, 1'b0, 8'h00);           // drop pulse lasts one cycle
        step(1'b1, 3'd3, 1'b0, 8'h08);
        step(1'b1, 3'd6, 1'b0, 8'h01);           // ack on non-pending bit is harmless
        step(1'b0, 3'd0, 1'b0, 8'h48);

        // 4: flush beats a valid code and ack, keeps drop counter
        foreach (m_pend[i]) ;
        step(1'b1, 3'd0, 1'b0, 8'h00);
        step(1'b1, 3'd2, 1'b0, 8'h00);
        step(1'b1, 3'd5, 1'b0, 8'h00);
        step(1'b1, 3'd7, 1'b0, 8'h00);
        chk("t4_a5", {24'd0, pending}, 32'hA5);
        step(1'b1, 3'd1, 1'b1, 8'h01);
        chk("t4_flushed", {24'd0, pending}, 32'h00);

        // 5: 300 forced drops saturate the counter
        step(1'b1, 3'd1, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) step(1'b1, 3'd1, 1'b0, 8'h00);
`ifdef DISPATCH_DROP_CNT_EN
        chk("t5_saturated", {24'd0, drop_cnt}, 32'hFF);
`else
        chk("t5_no_counter", {24'd0, drop_cnt}, 32'h00);
`endif
        step(1'b0, 3'd0, 1'b0, 8'hFF);

        // 6: asynchronous reset mid-stream with pending=8'h3C
        for (int i = 2; i < 6; i++) step(1'b1, 3'(i), 1'b0, 8'h00);
        chk("t6_3c", {24'd0, pending}, 32'h3C);
        in_valid = 1'b1; in_idx = 3'd7;
        #2 rst = 1'b1;
        #1;
        m_pend = '0; m_dcnt = '0; m_rdy = 1'b0;
        chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_pending",  {24'd0, pending},  32'd0);
        chk("t6_pend_cnt", {28'd0, pend_cnt}, 32'd0);
        chk("t6_irq",      {31'd0, irq},      32'd0);
        chk("t6_drop",     {31'd0, drop},     32'd0);
        chk("t6_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step(1'b0, 3'd0, 1'b0, 8'h00);          // in_ready still 0 before the edge
        step(1'b1, 3'd4, 1'b0, 8'h00);          // accepted again after release
        chk("t6_after", {24'd0, pending}, 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
